dcache_flush_unit: RTL and testbench
====================================

Name: dcache_flush_unit

Overview:
- Responder side of the data-cache flush/init handshake driven by the core's flush controller.
- On flush_i, walks every set/way of the write-back dcache, writes back dirty lines, invalidates all lines, then pulses flush_ack_o.
- On init_i, invalidates every line with no write-back; used after micro-architectural reset.
- Sits inside the dcache, between the tag/data arrays and the miss/write-back memory port.

Parameters:
NUM_SETS, 256, number of sets (power of 2, >=2); IDX_W = log2(NUM_SETS)
NUM_WAYS, 8, associativity (power of 2, >=1); WAY_W = max(1, log2(NUM_WAYS))
PLEN, 56, physical address width
OFFSET_W, 4, line byte-offset width; TAG_W = PLEN-IDX_W-OFFSET_W
LINE_W, 128, line data width in bits

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  flush request level; held until flush_ack_o
flush_ack_o  out  1  one-cycle pulse: flush complete
init_i  in  1  invalidate-all request, single-cycle pulse
init_done_o  out  1  one-cycle pulse: init complete
busy_o  out  1  engine active; the cache must not accept core requests
arr_req_o  out  1  array access strobe
arr_we_o  out  1  1 = write valid=0/dirty=0 to the addressed line; 0 = read
arr_idx_o  out  IDX_W  set index
arr_way_o  out  WAY_W  way
arr_valid_i  in  1  read valid bit; returned the cycle after a read
arr_dirty_i  in  1  read dirty bit; same timing
arr_tag_i  in  TAG_W  read tag; same timing
arr_data_i  in  LINE_W  read line data; same timing
wb_req_o  out  1  write-back request
wb_gnt_i  in  1  write-back grant
wb_addr_o  out  PLEN  {tag, idx, OFFSET_W'b0}
wb_data_o  out  LINE_W  write-back data
wb_ack_i  in  1  write-back completed; at most one outstanding

Behaviour:
- States: IDLE, READ, CHECK, WB_REQ, WB_WAIT, INVAL, ACK.
- Mode register: FLUSH or INIT.
- Line counter {idx, way}: way is the inner loop, idx the outer. Order: (0,0), (0,1) … (NUM_SETS-1, NUM_WAYS-1).
- Reset: state=IDLE, counter=0, init-pending=0, all outputs 0.
- IDLE:
  - flush_i=1 -> mode=FLUSH, counter=0, go to READ. Flush has priority.
  - If init_i arrives in the same cycle, or at any cycle while busy, set init-pending. Pending inits coalesce into one.
  - Else if init_i=1 or init-pending=1 -> mode=INIT, clear pending, go to INVAL.
- READ: arr_req_o=1, arr_we_o=0, current idx/way -> CHECK.
- CHECK: array outputs are valid this cycle.
  - valid&dirty -> latch tag/data into the write-back registers -> WB_REQ.
  - valid&!dirty -> INVAL.
  - !valid -> advance.
- WB_REQ: wb_req_o=1 with wb_addr_o/wb_data_o stable until the cycle wb_gnt_i=1 is sampled, then WB_WAIT. Request is never withdrawn.
- WB_WAIT: wb_req_o=0; on wb_ack_i -> INVAL. An ack arriving in the grant cycle is honoured next cycle; the requester holds it.
- INVAL: arr_req_o=1, arr_we_o=1 -> advance.
- advance:
  - Last line -> ACK.
  - Else increment counter; next state is READ (FLUSH) or INVAL (INIT).
- ACK: flush_ack_o=1 (FLUSH) or init_done_o=1 (INIT) for exactly one cycle -> IDLE.
- flush_i may still be high in the IDLE cycle after ACK and is ignored for that one cycle. Track with an ack-just-sent flag. The requester deasserts within one cycle of the ack.
- busy_o = (state != IDLE).
- Counter wraps to 0 on completion.
- Per-line cost in FLUSH mode:
  - invalid line: 2 cycles
  - clean line: 3 cycles
  - dirty line: 3 cycles + grant wait + ack wait + 1
- Per-line cost in INIT mode: 1 cycle.
- Reset mid-operation: return to IDLE immediately, no ack, pending cleared, wb_req_o dropped. Array contents are left partially walked. The memory side is reset by the same reset.
- arr_idx_o/arr_way_o always drive the counter. wb_* outputs hold their last values when not requesting.

Test Plan:
1. NUM_SETS=4, NUM_WAYS=2, all lines invalid. flush_i rises at cycle 0 -> 8 READ/CHECK pairs in cycles 1–16, no wb_req_o, flush_ack_o=1 only at cycle 17, busy_o=1 in cycles 1–17.
2. Line (2,1) valid+dirty, tag=0x5A, others invalid; wb_gnt_i 3 cycles after wb_req_o, wb_ack_i 2 cycles after grant. Required response:
   - exactly one write-back with wb_addr_o = {0x5A, 2'd2, 4'h0} and data matching the array;
   - an INVAL write to (2,1);
   - flush_ack_o at cycle 17 + 1 (INVAL) + 1 (WB_REQ entry) + 3 + 2.
3. init_i pulse in IDLE -> arr_we_o=1 for cycles 1–8 covering every idx/way in order, init_done_o at cycle 9, no wb_req_o.
4. init_i during a flush walk -> flush completes normally with flush_ack_o; IDLE for one cycle; then the init walk runs and ends with init_done_o. Two init_i pulses during the flush yield a single init walk.
5. flush_i and init_i both asserted in IDLE -> the flush runs first, then the init; flush_ack_o precedes init_done_o.
6. rst_i asserted while in WB_REQ -> the next cycle shows state IDLE, wb_req_o=0, busy_o=0, no ack. A fresh flush_i then runs a complete walk from line (0,0).

Source files
------------

// File: rtl/dcache_flush_unit.sv
// Flush/init engine for the write-back dcache: walks every set/way, writes back
// dirty lines on flush, invalidates every line, then pulses a completion strobe.
module dcache_flush_unit #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 8,
    parameter int PLEN     = 56,
    parameter int OFFSET_W = 4,
    parameter int LINE_W   = 128,
    localparam int IDX_W   = $clog2(NUM_SETS),
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int TAG_W   = PLEN - IDX_W - OFFSET_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    output logic              flush_ack_o,
    input  logic              init_i,
    output logic              init_done_o,
    output logic              busy_o,
    output logic              arr_req_o,
    output logic              arr_we_o,
    output logic [IDX_W-1:0]  arr_idx_o,
    output logic [WAY_W-1:0]  arr_way_o,
    input  logic              arr_valid_i,
    input  logic              arr_dirty_i,
    input  logic [TAG_W-1:0]  arr_tag_i,
    input  logic [LINE_W-1:0] arr_data_i,
    output logic              wb_req_o,
    input  logic              wb_gnt_i,
    output logic [PLEN-1:0]   wb_addr_o,
    output logic [LINE_W-1:0] wb_data_o,
    input  logic              wb_ack_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_WB_REQ  = 3'd3;
    localparam logic [2:0] S_WB_WAIT = 3'd4;
    localparam logic [2:0] S_INVAL   = 3'd5;
    localparam logic [2:0] S_ACK     = 3'd6;

    localparam logic MODE_FLUSH = 1'b0;
    localparam logic MODE_INIT  = 1'b1;

    logic [2:0]        state_q, state_d;
    logic              mode_q, mode_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic              init_pend_q, init_pend_d;
    logic              ack_sent_q, ack_sent_d;
    logic [PLEN-1:0]   wb_addr_q, wb_addr_d;
    logic [LINE_W-1:0] wb_data_q, wb_data_d;

    logic              last_line;
    logic              last_way;
    logic [2:0]        adv_state;
    logic [IDX_W-1:0]  adv_idx;
    logic [WAY_W-1:0]  adv_way;

    // Way is the inner loop; the counter wraps to (0,0) once the last line is done.
    always_comb begin
        last_way  = (way_q == WAY_W'(NUM_WAYS - 1));
        last_line = last_way && (idx_q == IDX_W'(NUM_SETS - 1));
        adv_idx   = idx_q;
        adv_way   = way_q + WAY_W'(1);
        if (last_way) begin
            adv_way = '0;
            adv_idx = idx_q + IDX_W'(1);
        end
        if (last_line) begin
            adv_state = S_ACK;
            adv_idx   = '0;
            adv_way   = '0;
        end else if (mode_q == MODE_INIT) begin
            adv_state = S_INVAL;
        end else begin
            adv_state = S_READ;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        way_d       = way_q;
        init_pend_d = init_pend_q;
        ack_sent_d  = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;

        if (state_q != S_IDLE && init_i) begin
            init_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // flush_i may linger for one cycle after its ack; ignore it then.
                if (flush_i && !ack_sent_q) begin
                    mode_d  = MODE_FLUSH;
                    idx_d   = '0;
                    way_d   = '0;
                    state_d = S_READ;
                    if (init_i) begin
                        init_pend_d = 1'b1;
                    end
                end else if (init_i || init_pend_q) begin
                    mode_d      = MODE_INIT;
                    init_pend_d = 1'b0;
                    idx_d       = '0;
                    way_d       = '0;
                    state_d     = S_INVAL;
                end
            end
            S_READ: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (arr_valid_i && arr_dirty_i) begin
                    wb_addr_d = {arr_tag_i, idx_q, {OFFSET_W{1'b0}}};
                    wb_data_d = arr_data_i;
                    state_d   = S_WB_REQ;
                end else if (arr_valid_i) begin
                    state_d = S_INVAL;
                end else begin
                    state_d = adv_state;
                    idx_d   = adv_idx;
                    way_d   = adv_way;
                end
            end
            S_WB_REQ: begin
                if (wb_gnt_i) begin
                    state_d = S_WB_WAIT;
                end
            end
            S_WB_WAIT: begin
                if (wb_ack_i) begin
                    state_d = S_INVAL;
                end
            end
            S_INVAL: begin
                state_d = adv_state;
                idx_d   = adv_idx;
                way_d   = adv_way;
            end
            S_ACK: begin
                ack_sent_d = (mode_q == MODE_FLUSH);
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_FLUSH;
            idx_q       <= '0;
            way_q       <= '0;
            init_pend_q <= 1'b0;
            ack_sent_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            way_q       <= way_d;
            init_pend_q <= init_pend_d;
            ack_sent_q  <= ack_sent_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign arr_req_o   = (state_q == S_READ) || (state_q == S_INVAL);
    assign arr_we_o    = (state_q == S_INVAL);
    assign arr_idx_o   = idx_q;
    assign arr_way_o   = way_q;
    assign wb_req_o    = (state_q == S_WB_REQ);
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign flush_ack_o = (state_q == S_ACK) && (mode_q == MODE_FLUSH);
    assign init_done_o = (state_q == S_ACK) && (mode_q == MODE_INIT);

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Scoreboard bench for dcache_flush_unit: a line-level model of the cache array and
// memory port predicts reads, invalidates, write-backs and completion cycles.
module tb_dcache_flush_unit;

    localparam int NUM_SETS = 4;
    localparam int NUM_WAYS = 2;
    localparam int PLEN     = 16;
    localparam int OFFSET_W = 4;
    localparam int LINE_W   = 32;
    localparam int IDX_W    = 2;
    localparam int WAY_W    = 1;
    localparam int TAG_W    = PLEN - IDX_W - OFFSET_W;
    localparam int N_LINES  = NUM_SETS * NUM_WAYS;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              flush_ack_o;
    logic              init_i;
    logic              init_done_o;
    logic              busy_o;
    logic              arr_req_o;
    logic              arr_we_o;
    logic [IDX_W-1:0]  arr_idx_o;
    logic [WAY_W-1:0]  arr_way_o;
    logic              arr_valid_i;
    logic              arr_dirty_i;
    logic [TAG_W-1:0]  arr_tag_i;
    logic [LINE_W-1:0] arr_data_i;
    logic              wb_req_o;
    logic              wb_gnt_i;
    logic [PLEN-1:0]   wb_addr_o;
    logic [LINE_W-1:0] wb_data_o;
    logic              wb_ack_i;

    dcache_flush_unit #(
        .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .PLEN(PLEN),
        .OFFSET_W(OFFSET_W), .LINE_W(LINE_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
        .init_i(init_i), .init_done_o(init_done_o), .busy_o(busy_o),
        .arr_req_o(arr_req_o), .arr_we_o(arr_we_o), .arr_idx_o(arr_idx_o),
        .arr_way_o(arr_way_o), .arr_valid_i(arr_valid_i), .arr_dirty_i(arr_dirty_i),
        .arr_tag_i(arr_tag_i), .arr_data_i(arr_data_i), .wb_req_o(wb_req_o),
        .wb_gnt_i(wb_gnt_i), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .wb_ack_i(wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { bit is_init; bit rel; int cyc; } ev_t;
    typedef struct { logic [PLEN-1:0] addr; logic [LINE_W-1:0] data; } wb_t;

    ev_t ev_q[$];
    wb_t wb_q[$];
    int  rd_q[$];
    int  wr_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_ack_cyc = 0;
    int gnt_dly = 0;
    int ack_dly = 1;

    bit                mem_valid[N_LINES];
    bit                mem_dirty[N_LINES];
    logic [TAG_W-1:0]  mem_tag[N_LINES];
    logic [LINE_W-1:0] mem_data[N_LINES];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s: got an output, expected none (cycle %0d)", name, cyc);
    endtask

    // Array and memory-port environment: the array answers a read one cycle later,
    // the memory grants gnt_dly cycles after a request and acks ack_dly after grant.
    initial begin
        int p_req, p_we, p_line, rsp_st, rsp_cnt;
        p_req = 0; p_we = 0; p_line = 0; rsp_st = 0; rsp_cnt = 0;
        wb_gnt_i = 1'b0; wb_ack_i = 1'b0;
        arr_valid_i = 1'b0; arr_dirty_i = 1'b0; arr_tag_i = '0; arr_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (p_req != 0) begin
                if (p_we != 0) begin
                    mem_valid[p_line] = 1'b0;
                    mem_dirty[p_line] = 1'b0;
                end else begin
                    arr_valid_i = mem_valid[p_line];
                    arr_dirty_i = mem_dirty[p_line];
                    arr_tag_i   = mem_tag[p_line];
                    arr_data_i  = mem_data[p_line];
                end
            end
            p_req  = int'(arr_req_o);
            p_we   = int'(arr_we_o);
            p_line = int'(arr_idx_o) * NUM_WAYS + int'(arr_way_o);
            wb_gnt_i = 1'b0;
            wb_ack_i = 1'b0;
            if (rst_i) begin
                rsp_st = 0;
            end else if (rsp_st == 0) begin
                if (wb_req_o) begin
                    if (gnt_dly == 0) begin
                        wb_gnt_i = 1'b1; rsp_st = 2; rsp_cnt = ack_dly;
                    end else begin
                        rsp_st = 1; rsp_cnt = gnt_dly;
                    end
                end
            end else if (rsp_st == 1) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    wb_gnt_i = 1'b1; rsp_st = 2; rsp_cnt = ack_dly;
                end
            end else begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    wb_ack_i = 1'b1; rsp_st = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an observable event.
    always @(negedge clk_i) begin
        wb_t w;
        ev_t e;
        int  exp_cyc;
        if (!rst_i) begin
            if (arr_req_o && !arr_we_o) begin
                if (rd_q.size() == 0) unexpected("array read");
                else checkOutput("read line", 64'(int'(arr_idx_o) * NUM_WAYS + int'(arr_way_o)), 64'(rd_q.pop_front()));
            end
            if (arr_req_o && arr_we_o) begin
                if (wr_q.size() == 0) unexpected("array invalidate");
                else checkOutput("inval line", 64'(int'(arr_idx_o) * NUM_WAYS + int'(arr_way_o)), 64'(wr_q.pop_front()));
            end
            if (wb_req_o && wb_gnt_i) begin
                if (wb_q.size() == 0) unexpected("write-back");
                else begin
                    w = wb_q.pop_front();
                    checkOutput("wb addr", 64'(wb_addr_o), 64'(w.addr));
                    checkOutput("wb data", 64'(wb_data_o), 64'(w.data));
                end
            end
            if (flush_ack_o || init_done_o) begin
                if (ev_q.size() == 0) unexpected("completion pulse");
                else begin
                    e = ev_q.pop_front();
                    exp_cyc = e.rel ? last_ack_cyc + 2 + N_LINES : e.cyc;
                    checkOutput("done kind(init)", 64'(init_done_o), 64'(e.is_init));
                    checkOutput("done kind(flush)", 64'(flush_ack_o), 64'(!e.is_init));
                    checkOutput("done cycle", 64'(cyc), 64'(exp_cyc));
                    last_ack_cyc = cyc;
                end
            end
        end
    end

    task automatic fillArray(input int dens);
        for (int l = 0; l < N_LINES; l++) begin
            mem_valid[l] = ($urandom_range(99) < dens);
            mem_dirty[l] = mem_valid[l] && ($urandom_range(1) == 1);
            mem_tag[l]   = TAG_W'($urandom);
            mem_data[l]  = LINE_W'($urandom);
        end
    endtask

    // Reference model: flush reads every line, invalidates valid ones, writes back dirty ones.
    task automatic expectFlush(input int s);
        int  cost;
        wb_t w;
        cost = 0;
        for (int l = 0; l < N_LINES; l++) begin
            rd_q.push_back(l);
            if (!mem_valid[l]) begin
                cost += 2;
            end else begin
                wr_q.push_back(l);
                if (mem_dirty[l]) begin
                    w.addr = {mem_tag[l], IDX_W'(l / NUM_WAYS), {OFFSET_W{1'b0}}};
                    w.data = mem_data[l];
                    wb_q.push_back(w);
                    cost += 4 + gnt_dly + ack_dly;
                end else begin
                    cost += 3;
                end
            end
        end
        ev_q.push_back('{is_init: 1'b0, rel: 1'b0, cyc: s + 1 + cost});
    endtask

    task automatic expectInit(input bit rel, input int s);
        for (int l = 0; l < N_LINES; l++) wr_q.push_back(l);
        ev_q.push_back('{is_init: 1'b1, rel: rel, cyc: s + 1 + N_LINES});
    endtask

    task automatic waitIdle();
        int waited;
        int nvalid;
        waited = 0;
        while ((ev_q.size() != 0 || busy_o) && waited < 3000) begin
            @(negedge clk_i);
            waited++;
        end
        if (ev_q.size() != 0 || busy_o) begin
            checkOutput("completion timeout", 64'(ev_q.size()), 64'(0));
            ev_q.delete();
        end
        @(negedge clk_i);
        checkOutput("leftover expectations", 64'(rd_q.size() + wr_q.size() + wb_q.size()), 64'(0));
        rd_q.delete(); wr_q.delete(); wb_q.delete();
        nvalid = 0;
        for (int l = 0; l < N_LINES; l++) nvalid += int'(mem_valid[l]) + int'(mem_dirty[l]);
        checkOutput("lines left valid/dirty", 64'(nvalid), 64'(0));
    endtask

    task automatic applyStimulus(input bit do_flush, input bit init_now, input int mid_inits);
        int s;
        int waited;
        @(negedge clk_i);
        s = cyc;
        if (do_flush) expectFlush(s);
        if (init_now || mid_inits > 0) expectInit(do_flush, s);
        flush_i = do_flush;
        init_i  = init_now;
        @(negedge clk_i);
        init_i = 1'b0;
        for (int k = 0; k < mid_inits; k++) begin
            repeat (2) @(negedge clk_i);
            init_i = 1'b1;
            @(negedge clk_i);
            init_i = 1'b0;
        end
        if (do_flush) begin
            waited = 0;
            while (!flush_ack_o && waited < 3000) begin
                @(negedge clk_i);
                waited++;
            end
            if (!flush_ack_o) checkOutput("flush ack timeout", 64'(flush_ack_o), 64'(1));
            @(negedge clk_i);
            flush_i = 1'b0;
        end
        waitIdle();
    endtask

    initial begin
        int waited;
        rst_i = 1'b1; flush_i = 1'b0; init_i = 1'b0;
        for (int l = 0; l < N_LINES; l++) begin
            mem_valid[l] = 1'b0; mem_dirty[l] = 1'b0; mem_tag[l] = '0; mem_data[l] = '0;
        end
        repeat (3) @(negedge clk_i);
        checkOutput("reset busy", 64'(busy_o), 64'(0));
        checkOutput("reset arr_req", 64'(arr_req_o), 64'(0));
        checkOutput("reset wb_req", 64'(wb_req_o), 64'(0));
        checkOutput("reset flush_ack", 64'(flush_ack_o), 64'(0));
        checkOutput("reset init_done", 64'(init_done_o), 64'(0));
        checkOutput("reset counter", 64'({arr_idx_o, arr_way_o}), 64'(0));
        checkOutput("reset wb_addr", 64'(wb_addr_o), 64'(0));
        rst_i = 1'b0;

        $display("[TB] all-invalid flush");
        applyStimulus(1'b1, 1'b0, 0);

        $display("[TB] single dirty line flush");
        mem_valid[5] = 1'b1; mem_dirty[5] = 1'b1; mem_tag[5] = TAG_W'(10'h05A); mem_data[5] = 32'hDEADBEEF;
        gnt_dly = 3; ack_dly = 2;
        applyStimulus(1'b1, 1'b0, 0);

        $display("[TB] init from idle");
        fillArray(60);
        applyStimulus(1'b0, 1'b1, 0);

        $display("[TB] two inits during a flush");
        fillArray(70); gnt_dly = 1; ack_dly = 1;
        applyStimulus(1'b1, 1'b0, 2);

        $display("[TB] flush and init together");
        fillArray(50);
        applyStimulus(1'b1, 1'b1, 0);

        $display("[TB] reset during write-back request");
        for (int l = 0; l < N_LINES; l++) begin mem_valid[l] = 1'b0; mem_dirty[l] = 1'b0; end
        mem_valid[2] = 1'b1; mem_dirty[2] = 1'b1; mem_tag[2] = TAG_W'(10'h123); mem_data[2] = 32'h0BADF00D;
        gnt_dly = 40; ack_dly = 1;
        @(negedge clk_i);
        expectFlush(cyc);
        flush_i = 1'b1;
        waited = 0;
        while (!wb_req_o && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        checkOutput("reach wb_req", 64'(wb_req_o), 64'(1));
        rst_i = 1'b1; flush_i = 1'b0;
        @(negedge clk_i);
        checkOutput("post-reset busy", 64'(busy_o), 64'(0));
        checkOutput("post-reset wb_req", 64'(wb_req_o), 64'(0));
        checkOutput("post-reset ack", 64'(flush_ack_o), 64'(0));
        rst_i = 1'b0;
        ev_q.delete(); rd_q.delete(); wr_q.delete(); wb_q.delete();
        gnt_dly = 1;
        applyStimulus(1'b1, 1'b0, 0);

        $display("[TB] random operations");
        for (int it = 0; it < 25; it++) begin
            int op;
            op = int'($urandom_range(3));
            fillArray(int'($urandom_range(100)));
            gnt_dly = int'($urandom_range(3));
            ack_dly = int'($urandom_range(3, 1));
            case (op)
                0: applyStimulus(1'b1, 1'b0, 0);
                1: applyStimulus(1'b0, 1'b1, 0);
                2: applyStimulus(1'b1, 1'b1, 0);
                default: applyStimulus(1'b1, 1'b0, int'($urandom_range(2, 1)));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
